dp_ram_port_arbiter: RTL and testbench

- Shares one dp_ram instance (1 read port, 1 write port, 1-cycle read latency, bit-masked writes) between NUM_REQ requesters.
- Each port has its own independent round-robin arbiter and valid/ready handshake.
- Read data returns to the granted requester one cycle after its grant.
- Sits between cache/tag pipelines and the RAM. All requests are gated off while the RAM reports busy (init or BIST).

---
 rtl/dp_ram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_dp_ram_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_port_arbiter.sv
// Round-robin arbiter that shares one dp_ram (1 read port, 1 write port) between NUM_REQ requesters.
// Each RAM port has its own pointer. Read data returns one cycle after its grant.
module dp_ram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ram_busy,
  input  logic [NUM_REQ-1:0]               wr_req_valid,
  output logic [NUM_REQ-1:0]               wr_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_req_mask,
  input  logic [NUM_REQ-1:0]               rd_req_valid,
  output logic [NUM_REQ-1:0]               rd_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_req_addr,
  output logic [NUM_REQ-1:0]               rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]            rd_rsp_data,
  output logic                             ram_wr_en,
  output logic [ADDR_WIDTH-1:0]            ram_wr_addr,
  output logic [DATA_WIDTH-1:0]            ram_data_in,
  output logic [DATA_WIDTH-1:0]            ram_mask_in,
  output logic                             ram_rd_en,
  output logic [ADDR_WIDTH-1:0]            ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]            ram_data_out
);

  localparam logic [IDX_WIDTH:0]   REQ_W    = (IDX_WIDTH+1)'(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  logic [IDX_WIDTH-1:0]  wr_ptr;
  logic [IDX_WIDTH-1:0]  rd_ptr;
  logic [NUM_REQ-1:0]    rd_pend_oh;

  logic [ADDR_WIDTH-1:0] wr_addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_mask_a [NUM_REQ];
  logic [ADDR_WIDTH-1:0] rd_addr_a [NUM_REQ];

  logic [IDX_WIDTH:0]    wr_pick;
  logic [IDX_WIDTH:0]    rd_pick;
  logic                  wr_gnt_vld;
  logic                  rd_gnt_vld;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign wr_addr_a[g] = wr_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_a[g] = wr_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign wr_mask_a[g] = wr_req_mask[g*DATA_WIDTH +: DATA_WIDTH];
    assign rd_addr_a[g] = rd_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Returns {found, index}. The search starts at ptr and wraps modulo NUM_REQ,
  // which need not be a power of two.
  function automatic logic [IDX_WIDTH:0] rr_pick(
    input logic [NUM_REQ-1:0]   valid,
    input logic [IDX_WIDTH-1:0] ptr
  );
    logic                 found;
    logic [IDX_WIDTH-1:0] pick;
    logic [IDX_WIDTH:0]   cand;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_WIDTH+1)'(k);
      if (cand >= REQ_W) cand = cand - REQ_W;
      if (!found && valid[cand[IDX_WIDTH-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_WIDTH-1:0];
      end
    end
    return {found, pick};
  endfunction

  function automatic logic [IDX_WIDTH-1:0] next_ptr(input logic [IDX_WIDTH-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_WIDTH'(1);
  endfunction

  always_comb begin
    wr_pick = '0;
    rd_pick = '0;
    if (!rst && !ram_busy) begin
      wr_pick = rr_pick(wr_req_valid, wr_ptr);
      rd_pick = rr_pick(rd_req_valid, rd_ptr);
    end
  end

  assign wr_gnt_vld = wr_pick[IDX_WIDTH];
  assign wr_idx     = wr_pick[IDX_WIDTH-1:0];
  assign rd_gnt_vld = rd_pick[IDX_WIDTH];
  assign rd_idx     = rd_pick[IDX_WIDTH-1:0];

  always_comb begin
    wr_req_ready = '0;
    ram_wr_en    = 1'b0;
    ram_wr_addr  = '0;
    ram_data_in  = '0;
    ram_mask_in  = '0;
    if (wr_gnt_vld) begin
      wr_req_ready[wr_idx] = 1'b1;
      ram_wr_en            = 1'b1;
      ram_wr_addr          = wr_addr_a[wr_idx];
      ram_data_in          = wr_data_a[wr_idx];
      ram_mask_in          = wr_mask_a[wr_idx];
    end
  end

  always_comb begin
    rd_req_ready = '0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = '0;
    if (rd_gnt_vld) begin
      rd_req_ready[rd_idx] = 1'b1;
      ram_rd_en            = 1'b1;
      ram_rd_addr          = rd_addr_a[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pend_oh <= '0;
    end else begin
      if (wr_gnt_vld) wr_ptr <= next_ptr(wr_idx);
      if (rd_gnt_vld) rd_ptr <= next_ptr(rd_idx);
      rd_pend_oh <= rd_req_ready;
    end
  end

  assign rd_rsp_valid = rd_pend_oh;
  assign rd_rsp_data  = (|rd_pend_oh) ? ram_data_out : '0;

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Bench for dp_ram_port_arbiter: a behavioural dp_ram with collision bypass behind a 4-requester
// instance, plus a 3-requester instance for the non-power-of-two pointer wrap.
module tb_dp_ram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ram_busy;
  logic [3:0]   wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready, rd_rsp_valid;
  logic [31:0]  wr_req_addr, rd_req_addr;
  logic [127:0] wr_req_data, wr_req_mask;
  logic [31:0]  rd_rsp_data;
  logic         ram_wr_en, ram_rd_en;
  logic [7:0]   ram_wr_addr, ram_rd_addr;
  logic [31:0]  ram_data_in, ram_mask_in, ram_data_out;

  logic [2:0]   w3_valid, w3_ready, r3_valid, r3_ready, r3_rsp_valid;
  logic [23:0]  w3_addr, r3_addr;
  logic [95:0]  w3_data, w3_mask;
  logic [31:0]  r3_rsp_data;
  logic         ram3_wr_en, ram3_rd_en;
  logic [7:0]   ram3_wr_addr, ram3_rd_addr;
  logic [31:0]  ram3_data_in, ram3_mask_in;
  logic [31:0]  ram3_data_out;

  assign ram3_data_out = 32'h5A5A_5A5A;

  always #5 clk = ~clk;

  dp_ram_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .IDX_WIDTH(2)) u_dut (
    .clk(clk), .rst(rst), .ram_busy(ram_busy),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mask(wr_req_mask),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_mask_in(ram_mask_in), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .ram_data_out(ram_data_out)
  );

  dp_ram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .IDX_WIDTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .ram_busy(ram_busy),
    .wr_req_valid(w3_valid), .wr_req_ready(w3_ready), .wr_req_addr(w3_addr),
    .wr_req_data(w3_data), .wr_req_mask(w3_mask),
    .rd_req_valid(r3_valid), .rd_req_ready(r3_ready), .rd_req_addr(r3_addr),
    .rd_rsp_valid(r3_rsp_valid), .rd_rsp_data(r3_rsp_data),
    .ram_wr_en(ram3_wr_en), .ram_wr_addr(ram3_wr_addr), .ram_data_in(ram3_data_in),
    .ram_mask_in(ram3_mask_in), .ram_rd_en(ram3_rd_en), .ram_rd_addr(ram3_rd_addr),
    .ram_data_out(ram3_data_out)
  );

  // dp_ram model: 1-cycle read, bit-masked write, same-address read returns merged new data
  logic [31:0] mem [0:255];
  logic [31:0] merged;
  assign merged = (mem[ram_wr_addr] & ~ram_mask_in) | (ram_data_in & ram_mask_in);

  always @(posedge clk) begin
    if (ram_rd_en)
      ram_data_out <= (ram_wr_en && ram_wr_addr == ram_rd_addr) ? merged : mem[ram_rd_addr];
    if (ram_wr_en)
      mem[ram_wr_addr] <= merged;
  end

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int unsigned due;
    logic [3:0]  oh;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q [$];
  rsp_t mon_e;
  int   grant_q [$];

  always @(negedge clk) begin
    if (rd_rsp_valid != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rd_rsp_valid), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", 64'(rd_rsp_valid), 64'(mon_e.oh));
        check("rsp_data", 64'(rd_rsp_data), 64'(mon_e.data));
        check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      check("rsp_missing", 64'(rd_rsp_valid), 64'(exp_q[0].oh));
      mon_e = exp_q.pop_front();
    end
  end

  task automatic set_wr(input int i, input logic [7:0] a, input logic [31:0] d, input logic [31:0] m);
    wr_req_addr[i*8 +: 8]  = a;
    wr_req_data[i*32 +: 32] = d;
    wr_req_mask[i*32 +: 32] = m;
  endtask

  task automatic set_rd(input int i, input logic [7:0] a);
    rd_req_addr[i*8 +: 8] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(input logic [3:0] oh, input logic [31:0] d);
    rsp_t r;
    r.due  = cyc + 1;
    r.oh   = oh;
    r.data = d;
    exp_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    logic [31:0] exp_d;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    ram_busy = 1'b0;
    wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0; rd_req_addr = '0;
    w3_addr = '0; w3_data = '0; w3_mask = '0; r3_addr = '0;
    wr_req_valid = 4'hF; rd_req_valid = 4'hF; w3_valid = 3'b111; r3_valid = 3'b111;

    @(negedge clk);
    check("rst_wr_ready", 64'(wr_req_ready), 64'h0);
    check("rst_rd_ready", 64'(rd_req_ready), 64'h0);
    check("rst_wr_en", 64'(ram_wr_en), 64'h0);
    check("rst_rd_en", 64'(ram_rd_en), 64'h0);
    check("rst_rsp_valid", 64'(rd_rsp_valid), 64'h0);
    check("rst3_wr_ready", 64'(w3_ready), 64'h0);
    check("rst3_rd_ready", 64'(r3_ready), 64'h0);
    wr_req_valid = '0; rd_req_valid = '0; w3_valid = '0; r3_valid = '0;
    tick();
    rst = 1'b0;

    // round-robin writes, all requesters continuously valid
    for (int i = 0; i < 4; i++) set_wr(i, 8'(8'h40 + i), 32'(32'h1111_1111 * (i + 1)), 32'hFFFF_FFFF);
    wr_req_valid = 4'hF;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) grant_q.push_back(i);
    repeat (8) begin
      @(negedge clk);
      g = grant_q.pop_front();
      exp_d = 32'(32'h1111_1111 * (g + 1));
      check("rr_wr_ready", 64'(wr_req_ready), 64'(4'b0001 << g));
      check("rr_wr_addr", 64'(ram_wr_addr), 64'(8'h40 + g));
      check("rr_wr_data", 64'(ram_data_in), 64'(exp_d));
      tick();
    end
    wr_req_valid = '0;

    // requester 2 writes 0x10, requester 1 reads it back
    set_wr(2, 8'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    wr_req_valid = 4'b0100;
    @(negedge clk);
    check("w2_ready", 64'(wr_req_ready), 64'h4);
    check("w2_addr", 64'(ram_wr_addr), 64'h10);
    tick();
    wr_req_valid = '0;
    set_rd(1, 8'h10);
    rd_req_valid = 4'b0010;
    push_rsp(4'b0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("r1_ready", 64'(rd_req_ready), 64'h2);
    check("r1_addr", 64'(ram_rd_addr), 64'h10);
    check("r1_rd_en", 64'(ram_rd_en), 64'h1);
    tick();
    rd_req_valid = '0;
    @(negedge clk);
    check("r1_wr_idle", 64'(ram_wr_en), 64'h0);
    tick();
    @(negedge clk);
    check("rsp_one_shot", 64'(rd_rsp_valid), 64'h0);
    tick();

    // preload 0x20, then same-cycle masked write and read of 0x20
    set_wr(0, 8'h20, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    wr_req_valid = 4'b0001;
    @(negedge clk);
    check("pre_wr_ready", 64'(wr_req_ready), 64'h1);
    tick();
    set_wr(0, 8'h20, 32'h0000_FFFF, 32'h0000_FFFF);
    set_rd(3, 8'h20);
    wr_req_valid = 4'b0001;
    rd_req_valid = 4'b1000;
    push_rsp(4'b1000, 32'hAAAA_FFFF);
    @(negedge clk);
    check("col_wr_ready", 64'(wr_req_ready), 64'h1);
    check("col_rd_ready", 64'(rd_req_ready), 64'h8);
    check("col_mask", 64'(ram_mask_in), 64'h0000_FFFF);
    tick();
    wr_req_valid = '0;

    // busy gates all grants; arbitration resumes from rd_ptr=0
    ram_busy = 1'b1;
    set_rd(0, 8'h40);
    set_rd(2, 8'h42);
    rd_req_valid = 4'b0101;
    repeat (5) begin
      @(negedge clk);
      check("busy_rd_ready", 64'(rd_req_ready), 64'h0);
      check("busy_rd_en", 64'(ram_rd_en), 64'h0);
      tick();
    end
    ram_busy = 1'b0;
    push_rsp(4'b0001, 32'h1111_1111);
    @(negedge clk);
    check("unbusy_first", 64'(rd_req_ready), 64'h1);
    tick();
    push_rsp(4'b0100, 32'h3333_3333);
    @(negedge clk);
    check("unbusy_second", 64'(rd_req_ready), 64'h4);
    tick();

    // busy rising right after a grant still delivers the response
    set_rd(1, 8'h41);
    rd_req_valid = 4'b0010;
    push_rsp(4'b0010, 32'h2222_2222);
    @(negedge clk);
    check("pre_busy_gnt", 64'(rd_req_ready), 64'h2);
    tick();
    ram_busy = 1'b1;
    @(negedge clk);
    check("busy_edge_ready", 64'(rd_req_ready), 64'h0);
    tick();
    ram_busy = 1'b0;
    rd_req_valid = '0;

    // reset while a response is outstanding
    set_rd(0, 8'h40);
    rd_req_valid = 4'b0001;
    @(negedge clk);
    check("mid_gnt", 64'(rd_req_ready), 64'h1);
    tick();
    rd_req_valid = '0;
    check("pre_rst_rsp", 64'(rd_rsp_valid), 64'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 64'(rd_rsp_valid), 64'h0);
    check("mid_rst_rsp_data", 64'(rd_rsp_data), 64'h0);
    tick();
    rst = 1'b0;
    wr_req_valid = 4'hF;
    rd_req_valid = 4'hF;
    push_rsp(4'b0001, 32'h1111_1111);
    @(negedge clk);
    check("post_rst_wr_ptr", 64'(wr_req_ready), 64'h1);
    check("post_rst_rd_ptr", 64'(rd_req_ready), 64'h1);
    tick();
    wr_req_valid = '0;
    rd_req_valid = '0;

    // NUM_REQ=3: grant to the last requester wraps the pointer to 0
    r3_addr[16 +: 8] = 8'h77;
    r3_valid = 3'b100;
    w3_valid = 3'b100;
    @(negedge clk);
    check("n3_rd_last", 64'(r3_ready), 64'h4);
    check("n3_wr_last", 64'(w3_ready), 64'h4);
    check("n3_rd_addr", 64'(ram3_rd_addr), 64'h77);
    tick();
    r3_valid = 3'b011;
    w3_valid = 3'b011;
    @(negedge clk);
    check("n3_rd_wrap", 64'(r3_ready), 64'h1);
    check("n3_wr_wrap", 64'(w3_ready), 64'h1);
    check("n3_rsp_valid", 64'(r3_rsp_valid), 64'h4);
    check("n3_rsp_data", 64'(r3_rsp_data), 64'h5A5A_5A5A);
    tick();
    r3_valid = '0;
    w3_valid = '0;
    @(negedge clk);
    check("n3_rsp_valid2", 64'(r3_rsp_valid), 64'h1);
    tick();
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
